pwr_seq_fsm: RTL
================

// Module: pwr_seq_fsm
// PURPOSE
//  Always-on power-domain sequencer that sits directly upstream of the power-controller delay counter.
//  - Runs the sleep/wake handshakes with the switchable domain and the power switch.
//  - Drives the level controls (iso, ret, rstn, clk_en) and the sleep/on acks the delay counter consumes.
//  - Holds each sequence state long enough for the downstream staggered delays to complete.
// PARAMETERS
//  TO_W        8    width of handshake timeout counter
//  ACK_TIMEOUT 200  cycles allowed for i_dom_idle_ack / i_pwr_good before error (< 2**TO_W)
// PORTS
//  i_aon_clk             in   1  always-on clock
//  i_soc_pwr_on_rst_n    in   1  asynchronous active-low reset
//  i_sleep_req           in   1  level; request domain power-down
//  i_wake_req            in   1  level; request domain power-up (wins over i_sleep_req)
//  i_dom_idle_ack        in   1  domain quiesced, response to o_dom_idle_req
//  i_pwr_good            in   1  power switch output stable
//  i_pwr_off_seq_delay   in   4  per-step delay used downstream during power-off
//  i_pwr_on_seq_delay    in   4  per-step delay used downstream during power-on
//  i_err_clr             in   1  clears o_timeout_err
//  o_dom_idle_req        out  1  ask domain to quiesce
//  o_pwr_sw_en           out  1  power switch enable
//  o_iso/o_ret/o_rstn/o_clk_en out 1 each  raw controls to the delay counter
//  o_hw_sleep_ack        out  1  level; high in PD_SEQ and OFF
//  o_pwr_on_ack          out  1  level; high in PU_SEQ and ACTIVE
//  o_state               out  3  current state encoding
//  o_timeout_err         out  1  sticky handshake-timeout flag
// BEHAVIOUR
//  Reset (async, any time incl. mid-sequence) -> state BOOT; all outputs take their reset values immediately.
//  - Reset values: o_pwr_sw_en=1, o_clk_en=1, o_iso=0, o_ret=0, o_rstn=0.
//  - Reset values: o_dom_idle_req=0, both acks=0, o_timeout_err=0, counters=0.
//  States/encoding: BOOT=0 ACTIVE=1 IDLE_REQ=2 PD_SEQ=3 OFF=4 PU_WAIT=5 PU_SEQ=6; 7 unreachable -> BOOT.
//  BOOT: on i_pwr_good -> PU_SEQ.
//  ACTIVE: i_sleep_req & ~i_wake_req -> IDLE_REQ, o_dom_idle_req=1, timeout cnt=0.
//  IDLE_REQ: i_wake_req -> ACTIVE, o_dom_idle_req=0 (abort). Else i_dom_idle_ack -> PD_SEQ.
//   Else cnt==ACK_TIMEOUT-1 -> ACTIVE, o_dom_idle_req=0, o_timeout_err=1.
//  PD_SEQ entry: o_clk_en=0, o_iso=1, o_ret=1, o_rstn=0, o_hw_sleep_ack=1, o_pwr_on_ack=0, settle cnt=0.
//   Stays N=max(1,4*i_pwr_off_seq_delay) cycles; then o_pwr_sw_en=0 -> OFF. o_dom_idle_req held.
//  OFF: i_wake_req -> PU_WAIT, o_pwr_sw_en=1, o_hw_sleep_ack=0, timeout cnt=0. Level controls unchanged.
//  PU_WAIT: i_pwr_good -> PU_SEQ. cnt==ACK_TIMEOUT-1 -> OFF, o_pwr_sw_en=0, o_hw_sleep_ack=1, o_timeout_err=1.
//  PU_SEQ entry: o_clk_en=1, o_iso=0, o_ret=0, o_rstn=1, o_pwr_on_ack=1, o_dom_idle_req=0.
//   Stays N=max(1,4*i_pwr_on_seq_delay) cycles -> ACTIVE.
//  Delay inputs are sampled once at PD_SEQ/PU_SEQ entry; later changes do not affect the running sequence.
//  Settle counter is 6 bits: {delay,2'b00}, max 60, no wrap. Timeout counter saturates, never wraps.
//  All outputs are registered; state change is visible 1 cycle after the triggering input is sampled.
//  o_timeout_err: set has priority over i_err_clr in the same cycle; otherwise i_err_clr clears it.
//  i_sleep_req is ignored outside ACTIVE. i_wake_req is ignored in PD_SEQ and acted on in OFF.
// TESTING
//  Reset release with i_pwr_good=1, on_delay=2 -> PU_SEQ 8 cycles, rstn=1/clk_en=1/pwr_on_ack=1, then ACTIVE.
//  ACTIVE, sleep_req, idle_ack 3 cycles later, off_delay=3 -> PD_SEQ 12 cycles, then pwr_sw_en=0, OFF, hw_sleep_ack=1.
//  IDLE_REQ with no idle_ack -> ACTIVE after exactly 200 cycles, timeout_err=1; err_clr clears it.
//  OFF, wake_req, pwr_good never rises -> OFF after 200 cycles, pwr_sw_en=0, err=1; retry with pwr_good -> ACTIVE.
//  sleep_req and wake_req both high in ACTIVE -> stays ACTIVE; wake_req in IDLE_REQ -> aborts, idle_req=0.
//  Reset asserted mid-PD_SEQ -> all outputs at reset values in the same cycle; off_delay=0 -> PD_SEQ lasts 1 cycle.

Source files
------------

// File: rtl/pwr_seq_fsm_if.sv
// ============================================================================
// Module : pwr_seq_fsm_if
// Brief  : Handshake and control bundle between the power sequencer and its peers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwr_seq_fsm_if;
    logic       i_sleep_req;
    logic       i_wake_req;
    logic       i_dom_idle_ack;
    logic       i_pwr_good;
    logic [3:0] i_pwr_off_seq_delay;
    logic [3:0] i_pwr_on_seq_delay;
    logic       i_err_clr;
    logic       o_dom_idle_req;
    logic       o_pwr_sw_en;
    logic       o_iso;
    logic       o_ret;
    logic       o_rstn;
    logic       o_clk_en;
    logic       o_hw_sleep_ack;
    logic       o_pwr_on_ack;
    logic [2:0] o_state;
    logic       o_timeout_err;

    // Requester side: drives the requests and handshake responses
    modport master (
        output i_sleep_req, i_wake_req, i_dom_idle_ack, i_pwr_good,
               i_pwr_off_seq_delay, i_pwr_on_seq_delay, i_err_clr,
        input  o_dom_idle_req, o_pwr_sw_en, o_iso, o_ret, o_rstn, o_clk_en,
               o_hw_sleep_ack, o_pwr_on_ack, o_state, o_timeout_err
    );

    // Sequencer side
    modport slave (
        input  i_sleep_req, i_wake_req, i_dom_idle_ack, i_pwr_good,
               i_pwr_off_seq_delay, i_pwr_on_seq_delay, i_err_clr,
        output o_dom_idle_req, o_pwr_sw_en, o_iso, o_ret, o_rstn, o_clk_en,
               o_hw_sleep_ack, o_pwr_on_ack, o_state, o_timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/pwr_seq_fsm.sv
// ============================================================================
// Module : pwr_seq_fsm
// Brief  : Always-on sleep/wake sequencer driving iso/ret/rstn/clk_en and acks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwr_seq_fsm #(
    parameter int TO_W        = 8,
    parameter int ACK_TIMEOUT = 200
) (
    input  wire logic    i_aon_clk,
    input  wire logic    i_soc_pwr_on_rst_n,
    pwr_seq_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_ACTIVE   = 3'd1,
        S_IDLE_REQ = 3'd2,
        S_PD_SEQ   = 3'd3,
        S_OFF      = 3'd4,
        S_PU_WAIT  = 3'd5,
        S_PU_SEQ   = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] c_to_last = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_to_max  = '1;

    state_t          r_state,      w_state;
    logic [TO_W-1:0] r_to_cnt,     w_to_cnt;
    logic [5:0]      r_settle_cnt, w_settle_cnt;
    logic [5:0]      r_settle_end, w_settle_end;
    logic            r_idle_req,   w_idle_req;
    logic            r_sw_en,      w_sw_en;
    logic            r_iso,        w_iso;
    logic            r_ret,        w_ret;
    logic            r_rstn,       w_rstn;
    logic            r_clk_en,     w_clk_en;
    logic            r_sleep_ack,  w_sleep_ack;
    logic            r_on_ack,     w_on_ack;
    logic            r_err,        w_err;
    logic            w_err_set;

    // Last settle-count value for a sequence of max(1, 4*delay) cycles
    function automatic logic [5:0] settle_end(input logic [3:0] d);
        return (d == 4'd0) ? 6'd0 : ({d, 2'b00} - 6'd1);
    endfunction

    always_comb begin
        w_state      = r_state;
        w_to_cnt     = r_to_cnt;
        w_settle_cnt = r_settle_cnt;
        w_settle_end = r_settle_end;
        w_idle_req   = r_idle_req;
        w_sw_en      = r_sw_en;
        w_iso        = r_iso;
        w_ret        = r_ret;
        w_rstn       = r_rstn;
        w_clk_en     = r_clk_en;
        w_sleep_ack  = r_sleep_ack;
        w_on_ack     = r_on_ack;
        w_err_set    = 1'b0;

        case (r_state)
            S_BOOT: begin
                if (bus.i_pwr_good) begin
                    w_state      = S_PU_SEQ;
                    w_settle_cnt = 6'd0;
                    w_settle_end = settle_end(bus.i_pwr_on_seq_delay);
                    w_clk_en     = 1'b1;
                    w_iso        = 1'b0;
                    w_ret        = 1'b0;
                    w_rstn       = 1'b1;
                    w_on_ack     = 1'b1;
                    w_sleep_ack  = 1'b0;
                    w_idle_req   = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (bus.i_sleep_req && !bus.i_wake_req) begin
                    w_state    = S_IDLE_REQ;
                    w_idle_req = 1'b1;
                    w_to_cnt   = '0;
                end
            end
            S_IDLE_REQ: begin
                if (bus.i_wake_req) begin
                    w_state    = S_ACTIVE;
                    w_idle_req = 1'b0;
                end else if (bus.i_dom_idle_ack) begin
                    w_state      = S_PD_SEQ;
                    w_settle_cnt = 6'd0;
                    w_settle_end = settle_end(bus.i_pwr_off_seq_delay);
                    w_clk_en     = 1'b0;
                    w_iso        = 1'b1;
                    w_ret        = 1'b1;
                    w_rstn       = 1'b0;
                    w_sleep_ack  = 1'b1;
                    w_on_ack     = 1'b0;
                end else if (r_to_cnt == c_to_last) begin
                    w_state    = S_ACTIVE;
                    w_idle_req = 1'b0;
                    w_err_set  = 1'b1;
                end else if (r_to_cnt != c_to_max) begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_PD_SEQ: begin
                // Switch is opened only after the downstream staggered delays elapse
                if (r_settle_cnt == r_settle_end) begin
                    w_state = S_OFF;
                    w_sw_en = 1'b0;
                end else begin
                    w_settle_cnt = r_settle_cnt + 6'd1;
                end
            end
            S_OFF: begin
                if (bus.i_wake_req) begin
                    w_state     = S_PU_WAIT;
                    w_sw_en     = 1'b1;
                    w_sleep_ack = 1'b0;
                    w_to_cnt    = '0;
                end
            end
            S_PU_WAIT: begin
                if (bus.i_pwr_good) begin
                    w_state      = S_PU_SEQ;
                    w_settle_cnt = 6'd0;
                    w_settle_end = settle_end(bus.i_pwr_on_seq_delay);
                    w_clk_en     = 1'b1;
                    w_iso        = 1'b0;
                    w_ret        = 1'b0;
                    w_rstn       = 1'b1;
                    w_on_ack     = 1'b1;
                    w_sleep_ack  = 1'b0;
                    w_idle_req   = 1'b0;
                end else if (r_to_cnt == c_to_last) begin
                    w_state     = S_OFF;
                    w_sw_en     = 1'b0;
                    w_sleep_ack = 1'b1;
                    w_err_set   = 1'b1;
                end else if (r_to_cnt != c_to_max) begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            S_PU_SEQ: begin
                if (r_settle_cnt == r_settle_end) begin
                    w_state = S_ACTIVE;
                end else begin
                    w_settle_cnt = r_settle_cnt + 6'd1;
                end
            end
            default: begin
                w_state = S_BOOT;
            end
        endcase

        w_err = w_err_set ? 1'b1 : (bus.i_err_clr ? 1'b0 : r_err);
    end

    always_ff @(posedge i_aon_clk or negedge i_soc_pwr_on_rst_n) begin
        if (!i_soc_pwr_on_rst_n) begin
            r_state      <= S_BOOT;
            r_to_cnt     <= '0;
            r_settle_cnt <= 6'd0;
            r_settle_end <= 6'd0;
            r_idle_req   <= 1'b0;
            r_sw_en      <= 1'b1;
            r_iso        <= 1'b0;
            r_ret        <= 1'b0;
            r_rstn       <= 1'b0;
            r_clk_en     <= 1'b1;
            r_sleep_ack  <= 1'b0;
            r_on_ack     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_to_cnt     <= w_to_cnt;
            r_settle_cnt <= w_settle_cnt;
            r_settle_end <= w_settle_end;
            r_idle_req   <= w_idle_req;
            r_sw_en      <= w_sw_en;
            r_iso        <= w_iso;
            r_ret        <= w_ret;
            r_rstn       <= w_rstn;
            r_clk_en     <= w_clk_en;
            r_sleep_ack  <= w_sleep_ack;
            r_on_ack     <= w_on_ack;
            r_err        <= w_err;
        end
    end

    assign bus.o_state        = r_state;
    assign bus.o_dom_idle_req = r_idle_req;
    assign bus.o_pwr_sw_en    = r_sw_en;
    assign bus.o_iso          = r_iso;
    assign bus.o_ret          = r_ret;
    assign bus.o_rstn         = r_rstn;
    assign bus.o_clk_en       = r_clk_en;
    assign bus.o_hw_sleep_ack = r_sleep_ack;
    assign bus.o_pwr_on_ack   = r_on_ack;
    assign bus.o_timeout_err  = r_err;

endmodule

`default_nettype wire
